// File: rtl/board_ctrl.sv
// Game-state stage for the 4x4 grid renderer: cell colours, cursor, button
// interpretation, blinking cursor overlay and a retriggerable error flag.
module board_ctrl #(
  parameter int          BLINK_CYCLES = 25_000_000,
  parameter int          ERR_CYCLES   = 50_000_000,
  parameter logic [11:0] CURSOR_COLOR = 12'hFF0,
  parameter logic [11:0] GAP_COLOR    = 12'h7FF,
  parameter logic [11:0] BLANK_COLOR  = 12'h000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        btn_up,
  input  logic        btn_down,
  input  logic        btn_left,
  input  logic        btn_right,
  input  logic        btn_center,
  input  logic [11:0] sw,
  output logic [47:0] x1,
  output logic [47:0] x2,
  output logic [47:0] x3,
  output logic [47:0] x4,
  output logic        error,
  output logic [1:0]  cursor_row,
  output logic [1:0]  cursor_col
);

  localparam int BW = (BLINK_CYCLES > 2) ? $clog2(BLINK_CYCLES) : 1;
  localparam int EW = $clog2(ERR_CYCLES + 1);

  // Button bit order: 0 center, 1 up, 2 down, 3 left, 4 right.
  logic [4:0]    btn_raw;
  logic [4:0]    meta_q, sync_q, dly_q, evt;
  logic [11:0]   cell_q [16];
  logic [1:0]    cur_row_q, cur_row_d, cur_col_q, cur_col_d;
  logic [BW-1:0] blink_cnt_q;
  logic          phase_q;
  logic [EW-1:0] err_cnt_q;
  logic          cell_we, err_load, blink_rst;
  logic [47:0]   disp [4];

  assign btn_raw = {btn_right, btn_left, btn_down, btn_up, btn_center};
  assign evt     = sync_q & ~dly_q;

  // Only the highest-priority event is serviced; the rest are dropped.
  always_comb begin
    cur_row_d = cur_row_q;
    cur_col_d = cur_col_q;
    cell_we   = 1'b0;
    err_load  = 1'b0;
    blink_rst = 1'b0;
    if (evt[0]) begin
      if (sw == GAP_COLOR) err_load = 1'b1;
      else begin
        cell_we   = 1'b1;
        blink_rst = 1'b1;
      end
    end else if (evt[1]) begin
      if (cur_row_q == 2'd0) err_load = 1'b1;
      else begin
        cur_row_d = cur_row_q - 2'd1;
        blink_rst = 1'b1;
      end
    end else if (evt[2]) begin
      if (cur_row_q == 2'd3) err_load = 1'b1;
      else begin
        cur_row_d = cur_row_q + 2'd1;
        blink_rst = 1'b1;
      end
    end else if (evt[3]) begin
      if (cur_col_q == 2'd0) err_load = 1'b1;
      else begin
        cur_col_d = cur_col_q - 2'd1;
        blink_rst = 1'b1;
      end
    end else if (evt[4]) begin
      if (cur_col_q == 2'd3) err_load = 1'b1;
      else begin
        cur_col_d = cur_col_q + 2'd1;
        blink_rst = 1'b1;
      end
    end
  end

  always_comb begin
    for (int r = 0; r < 4; r++) begin
      disp[r] = '0;
      for (int c = 0; c < 4; c++) begin
        if (phase_q && cur_row_q == 2'(r) && cur_col_q == 2'(c))
          disp[r][12*c +: 12] = CURSOR_COLOR;
        else
          disp[r][12*c +: 12] = cell_q[r*4 + c];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q      <= '0;
      sync_q      <= '0;
      dly_q       <= '0;
      for (int i = 0; i < 16; i++) cell_q[i] <= BLANK_COLOR;
      cur_row_q   <= '0;
      cur_col_q   <= '0;
      blink_cnt_q <= '0;
      phase_q     <= 1'b0;
      err_cnt_q   <= '0;
      x1          <= {4{BLANK_COLOR}};
      x2          <= {4{BLANK_COLOR}};
      x3          <= {4{BLANK_COLOR}};
      x4          <= {4{BLANK_COLOR}};
      error       <= 1'b0;
      cursor_row  <= '0;
      cursor_col  <= '0;
    end else begin
      meta_q    <= btn_raw;
      sync_q    <= meta_q;
      dly_q     <= sync_q;
      cur_row_q <= cur_row_d;
      cur_col_q <= cur_col_d;
      if (cell_we) cell_q[{cur_row_q, cur_col_q}] <= sw;

      if (blink_rst) begin
        blink_cnt_q <= '0;
        phase_q     <= 1'b1;
      end else if (blink_cnt_q == BW'(BLINK_CYCLES - 1)) begin
        blink_cnt_q <= '0;
        phase_q     <= ~phase_q;
      end else begin
        blink_cnt_q <= blink_cnt_q + 1'b1;
      end

      // A new error reloads rather than extends the hold time.
      if (err_load)             err_cnt_q <= EW'(ERR_CYCLES);
      else if (err_cnt_q != '0) err_cnt_q <= err_cnt_q - 1'b1;

      x1         <= disp[0];
      x2         <= disp[1];
      x3         <= disp[2];
      x4         <= disp[3];
      error      <= (err_cnt_q != '0);
      cursor_row <= cur_row_q;
      cursor_col <= cur_col_q;
    end
  end

endmodule
